mul_stall_control_unit: RTL and testbench

- Next-generation main decoder for the RISC-V pipeline with M-extension support. It decodes opcode/funct3/funct7 in the ID stage into the datapath control signals.
- Adds a sequencer for a multi-cycle multiplier with parametrised latency. While the multiplier runs, the sequencer stalls PC and IF/ID.
- Sits between the IF/ID register and the ID/EX register, next to the hazard unit.

---
 rtl/mul_stall_control_unit_pkg.sv | 24 ++
 rtl/mul_stall_control_unit_if.sv | 33 +++
 rtl/mul_stall_control_unit_mul_sequencer.sv | 68 ++++++
 rtl/mul_stall_control_unit.sv | 87 ++++++++
 tb/tb_mul_stall_control_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mul_stall_control_unit_pkg.sv
// Shared decode constants and sequencer state for the M-extension main decoder.
// Imported by the interface, the multiplier sequencer and the top-level decoder.
package mul_stall_control_unit_pkg;

    localparam logic [6:0] ALU_R     = 7'b0110011;
    localparam logic [6:0] ALU_I     = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] JUMP      = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] ADD_OPCODE    = 2'b00;
    localparam logic [1:0] SUB_OPCODE    = 2'b01;
    localparam logic [1:0] R_TYPE_OPCODE = 2'b10;

    typedef enum logic {IDLE, BUSY} seq_state_t;

    function automatic int cnt_width(input int latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/mul_stall_control_unit_if.sv
// Decode-slot bundle: IF/ID instruction fields in, ID-stage control signals out.
// master = pipeline side driving the instruction, slave = decoder.
interface mul_stall_control_unit_if;
    logic       instr_valid;
    logic       flush;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       mul_sel;
    logic       mul_start;
    logic       stall;
    logic       illegal_instr;

    modport master (
        output instr_valid, flush, opcode, funct3, funct7,
        input  alu_op, alu_src, mem_read, mem_write, mem_2_reg, reg_write,
               branch, jump, mul_sel, mul_start, stall, illegal_instr
    );

    modport slave (
        input  instr_valid, flush, opcode, funct3, funct7,
        output alu_op, alu_src, mem_read, mem_write, mem_2_reg, reg_write,
               branch, jump, mul_sel, mul_start, stall, illegal_instr
    );
endinterface

// File: rtl/mul_stall_control_unit_mul_sequencer.sv
// Occupancy sequencer for the multi-cycle multiplier: holds decode for exactly
// MUL_LATENCY cycles, pulsing mul_start first and mul_done on the writeback cycle.
module mul_sequencer
    import mul_stall_control_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic is_mul,
    input  logic flush,
    output logic mul_start,
    output logic stall,
    output logic mul_done
);

    localparam int CNT_W = cnt_width(MUL_LATENCY);
    localparam bit MULTI = (MUL_LATENCY > 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             last;

    assign busy = (state == BUSY);
    assign last = (cnt == '0);

    always_comb begin
        mul_start = 1'b0;
        stall     = 1'b0;
        mul_done  = 1'b0;
        if (!flush) begin
            if (busy) begin
                stall    = !last;
                mul_done = last;
            end else if (is_mul) begin
                mul_start = 1'b1;
                stall     = MULTI;
                mul_done  = !MULTI;
            end
        end
    end

    // A flush abandons the MUL; the counter value is irrelevant once IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul && MULTI) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(MUL_LATENCY - 2);
                    end
                end
                BUSY: begin
                    if (last) state <= IDLE;
                    else      cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mul_stall_control_unit.sv
// ID-stage main decoder with M-extension: combinational opcode decode plus a
// sequencer that stalls PC and IF/ID while a multi-cycle MUL occupies decode.
module mul_stall_control_unit
    import mul_stall_control_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input logic                     clk,
    input logic                     rst,
    mul_stall_control_unit_if.slave bus
);

    logic is_mul;
    logic seq_start;
    logic seq_stall;
    logic seq_done;

    assign is_mul = bus.instr_valid && (bus.opcode == ALU_R) && (bus.funct7 == FUNCT7_MULDIV);

    mul_sequencer #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .is_mul    (is_mul),
        .flush     (bus.flush),
        .mul_start (seq_start),
        .stall     (seq_stall),
        .mul_done  (seq_done)
    );

    // Any active sequencer output means decode belongs to the MUL, not the opcode.
    always_comb begin
        bus.alu_op        = ADD_OPCODE;
        bus.alu_src       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_2_reg     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.branch        = 1'b0;
        bus.jump          = 1'b0;
        bus.mul_sel       = 1'b0;
        bus.mul_start     = 1'b0;
        bus.stall         = 1'b0;
        bus.illegal_instr = 1'b0;
        if (rst || bus.flush) begin
            bus.alu_op = ADD_OPCODE;
        end else if (seq_start || seq_stall || seq_done) begin
            bus.alu_op    = R_TYPE_OPCODE;
            bus.mul_start = seq_start;
            bus.stall     = seq_stall;
            bus.reg_write = seq_done;
            bus.mul_sel   = seq_done;
        end else if (bus.instr_valid) begin
            case (bus.opcode)
                ALU_R: begin
                    bus.alu_op    = R_TYPE_OPCODE;
                    bus.reg_write = 1'b1;
                end
                ALU_I: begin
                    bus.alu_src   = 1'b1;
                    bus.reg_write = 1'b1;
                end
                LOAD: begin
                    bus.alu_src   = 1'b1;
                    bus.mem_read  = 1'b1;
                    bus.mem_2_reg = 1'b1;
                    bus.reg_write = 1'b1;
                end
                STORE: begin
                    bus.alu_src   = 1'b1;
                    bus.mem_write = 1'b1;
                end
                BRANCH_EQ: begin
                    bus.branch = 1'b1;
                    bus.alu_op = SUB_OPCODE;
                end
                JUMP: begin
                    bus.jump      = 1'b1;
                    bus.reg_write = 1'b1;
                end
                default: bus.illegal_instr = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_stall_control_unit.sv
// Directed bench for the decoder: a MUL_LATENCY=4 instance and a MUL_LATENCY=1
// instance share the same stimulus; each check compares the packed control word.
module tb_mul_stall_control_unit;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mul_stall_control_unit_if if4 ();
    mul_stall_control_unit_if if1 ();

    mul_stall_control_unit #(.MUL_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    mul_stall_control_unit #(.MUL_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // {alu_op, alu_src, mem_read, mem_write, mem_2_reg, reg_write, branch, jump,
    //  mul_sel, mul_start, stall, illegal_instr}
    logic [12:0] obs4, obs1;
    assign obs4 = {if4.alu_op, if4.alu_src, if4.mem_read, if4.mem_write, if4.mem_2_reg,
                   if4.reg_write, if4.branch, if4.jump, if4.mul_sel, if4.mul_start,
                   if4.stall, if4.illegal_instr};
    assign obs1 = {if1.alu_op, if1.alu_src, if1.mem_read, if1.mem_write, if1.mem_2_reg,
                   if1.reg_write, if1.branch, if1.jump, if1.mul_sel, if1.mul_start,
                   if1.stall, if1.illegal_instr};

    localparam logic [12:0] E_ZERO   = 13'b00_0000_000_0000;
    localparam logic [12:0] E_ADD    = 13'b10_0000_100_0000;
    localparam logic [12:0] E_ADDI   = 13'b00_1000_100_0000;
    localparam logic [12:0] E_LOAD   = 13'b00_1101_100_0000;
    localparam logic [12:0] E_STORE  = 13'b00_1010_000_0000;
    localparam logic [12:0] E_BR     = 13'b01_0000_010_0000;
    localparam logic [12:0] E_JAL    = 13'b00_0000_101_0000;
    localparam logic [12:0] E_ILL    = 13'b00_0000_000_0001;
    localparam logic [12:0] E_MSTART = 13'b10_0000_000_0110;
    localparam logic [12:0] E_MWAIT  = 13'b10_0000_000_0010;
    localparam logic [12:0] E_MDONE  = 13'b10_0000_100_1000;
    localparam logic [12:0] E_M1     = 13'b10_0000_100_1100;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] F7_M   = 7'b0000001;

    task automatic drive(input logic v, input logic f, input logic [6:0] op, input logic [6:0] f7);
        if4.instr_valid = v;  if1.instr_valid = v;
        if4.flush       = f;  if1.flush       = f;
        if4.opcode      = op; if1.opcode      = op;
        if4.funct7      = f7; if1.funct7      = f7;
        if4.funct3      = 3'($urandom_range(0, 7));
        if1.funct3      = if4.funct3;
    endtask

    task automatic chk4(input string tag, input logic [12:0] exp);
        tests++;
        assert (obs4 === exp) else begin
            fails++;
            $error("FAIL %s (lat4): observed %b expected %b", tag, obs4, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [12:0] exp);
        tests++;
        assert (obs1 === exp) else begin
            fails++;
            $error("FAIL %s (lat1): observed %b expected %b", tag, obs1, exp);
        end
    endtask

    // Apply inputs just after a rising edge, check mid-cycle, then advance one cycle.
    task automatic step4(input logic v, input logic f, input logic [6:0] op, input logic [6:0] f7,
                         input string tag, input logic [12:0] exp);
        drive(v, f, op, f7);
        #2;
        chk4(tag, exp);
        @(posedge clk); #1;
    endtask

    task automatic step1(input logic v, input logic f, input logic [6:0] op, input logic [6:0] f7,
                         input string tag, input logic [12:0] exp);
        drive(v, f, op, f7);
        #2;
        chk1(tag, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, OP_R, 7'b0);
        @(posedge clk); #1;
        #2;
        chk4("reset_add", E_ZERO);
        chk1("reset_add", E_ZERO);
        @(posedge clk); #1;
        rst = 1'b0;

        step4(1, 0, OP_R,   7'b0,        "add",     E_ADD);
        step4(1, 0, OP_R,   7'b0100000,  "sub",     E_ADD);
        step4(1, 0, OP_I,   7'b0,        "addi",    E_ADDI);
        step4(1, 0, OP_LD,  7'b0,        "load",    E_LOAD);
        step4(1, 0, OP_ST,  7'b0,        "store",   E_STORE);
        step4(1, 0, OP_BR,  7'b0,        "branch",  E_BR);
        step4(1, 0, OP_JAL, 7'b0,        "jal",     E_JAL);
        step4(1, 0, 7'b1111111, 7'b0,    "illegal", E_ILL);
        step4(0, 0, OP_R,   F7_M,        "bubble",  E_ZERO);
        step4(0, 0, 7'b1111111, 7'b0,    "bubble_ill", E_ZERO);

        // Single MUL; decode inputs change during BUSY and must be ignored.
        step4(1, 0, OP_R,  F7_M, "mul_c0", E_MSTART);
        step4(1, 0, OP_LD, 7'b0, "mul_c1", E_MWAIT);
        step4(0, 0, OP_ST, 7'b0, "mul_c2", E_MWAIT);
        step4(1, 0, OP_I,  7'b0, "mul_c3", E_MDONE);
        step4(1, 0, OP_R,  7'b0, "mul_c4", E_ADD);

        // Back-to-back MULs: second launches on c4 with no dead cycle.
        step4(1, 0, OP_R, F7_M, "b2b_c0", E_MSTART);
        step4(1, 0, OP_R, F7_M, "b2b_c1", E_MWAIT);
        step4(1, 0, OP_R, F7_M, "b2b_c2", E_MWAIT);
        step4(1, 0, OP_R, F7_M, "b2b_c3", E_MDONE);
        step4(1, 0, OP_R, F7_M, "b2b_c4", E_MSTART);
        step4(1, 0, OP_R, F7_M, "b2b_c5", E_MWAIT);
        step4(1, 0, OP_R, F7_M, "b2b_c6", E_MWAIT);
        step4(1, 0, OP_R, F7_M, "b2b_c7", E_MDONE);
        step4(1, 0, OP_R, 7'b0, "b2b_c8", E_ADD);

        // Flush mid-MUL: squashed MUL never writes back, c3 decodes afresh.
        step4(1, 0, OP_R, F7_M, "fl2_c0", E_MSTART);
        step4(1, 0, OP_I, 7'b0, "fl2_c1", E_MWAIT);
        step4(1, 1, OP_I, 7'b0, "fl2_c2", E_ZERO);
        step4(1, 0, OP_I, 7'b0, "fl2_c3", E_ADDI);
        step4(1, 0, OP_R, 7'b0, "fl2_c4", E_ADD);

        // Flush on the final cycle suppresses the writeback.
        step4(1, 0, OP_R,  F7_M, "fl3_c0", E_MSTART);
        step4(1, 0, OP_R,  F7_M, "fl3_c1", E_MWAIT);
        step4(1, 0, OP_R,  F7_M, "fl3_c2", E_MWAIT);
        step4(1, 1, OP_R,  F7_M, "fl3_c3", E_ZERO);
        step4(1, 0, OP_BR, 7'b0, "fl3_c4", E_BR);

        // Flush while IDLE with a MUL presented: no launch, stays IDLE.
        step4(1, 1, OP_R,  F7_M, "fl_idle",      E_ZERO);
        step4(1, 0, OP_JAL, 7'b0, "fl_idle_next", E_JAL);

        // Reset at c1 aborts the MUL.
        step4(1, 0, OP_R, F7_M, "rst_c0", E_MSTART);
        rst = 1'b1;
        step4(1, 0, OP_R, 7'b0, "rst_c1", E_ZERO);
        rst = 1'b0;
        step4(0, 0, OP_R, 7'b0, "rst_c2", E_ZERO);
        step4(1, 0, OP_R, 7'b0, "rst_c3", E_ADD);

        // Reset and flush together.
        rst = 1'b1;
        step4(1, 1, OP_R, F7_M, "rst_flush", E_ZERO);
        rst = 1'b0;

        // MUL_LATENCY=1: single-cycle MULs, both written back, never stalled.
        step1(1, 0, OP_R, F7_M, "l1_mul_a", E_M1);
        step1(1, 0, OP_R, F7_M, "l1_mul_b", E_M1);
        step1(1, 0, OP_R, 7'b0, "l1_add",   E_ADD);
        step1(1, 1, OP_R, F7_M, "l1_flush", E_ZERO);
        step1(1, 0, OP_ST, 7'b0, "l1_store", E_STORE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
